// File: rtl/noc_pkg.sv
// Shared flit types, error-bit indices and a destination-match helper for the
// local network interface.
package noc_pkg;

  localparam int FLIT_W = 16;

  typedef logic [FLIT_W-1:0] flit_t;

  // Header view of a flit: payload in the top byte, destination X/Y below.
  typedef struct packed {
    logic [7:0] payload;
    logic [3:0] x;
    logic [3:0] y;
  } flit_hdr_t;

  localparam int ERR_CREDIT_OVF = 0;
  localparam int ERR_RX_OVF     = 1;
  localparam int ERR_MISROUTE   = 2;
  localparam int ERR_W          = 3;

  // True when the flit's destination coordinates name this node.
  function automatic logic is_local(input flit_t flit, input logic [3:0] x,
                                    input logic [3:0] y);
    flit_hdr_t hdr;
    hdr = flit_hdr_t'(flit);
    return (hdr.x == x) && (hdr.y == y);
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// First-word-fall-through synchronous FIFO. A write to a full FIFO is taken
// only when a read frees a slot in the same cycle; a read of an empty FIFO is
// ignored.
module noc_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_rd_s;
  logic             do_wr_s;

  // Pointer advance with explicit wrap so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    if (ptr == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return ptr + AW'(1);
    end
  endfunction

  assign full    = (count_r == CW'(DEPTH));
  assign empty   = (count_r == {CW{1'b0}});
  assign rd_data = mem_r[rd_ptr_r];

  // Qualify requests against current occupancy.
  always_comb begin
    do_rd_s = rd_en && !empty;
    do_wr_s = wr_en && (!full || do_rd_s);
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (do_rd_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/local_net_iface.sv
// Network interface between a local core and a router's L port: a TX FIFO
// drained under credit flow control and an RX FIFO that returns one credit
// per flit the core consumes. All net_* outputs are registered.
module local_net_iface
  import noc_pkg::*;
#(
  parameter int XCOORD   = 0,
  parameter int YCOORD   = 0,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int CREDITS  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FLIT_W-1:0]            core_tx_data_i,
  input  logic                         core_tx_valid_i,
  output logic                         core_tx_ready_o,
  output logic [FLIT_W-1:0]            net_tx_data_o,
  output logic                         net_tx_enable_o,
  input  logic                         net_tx_credit_i,
  input  logic [FLIT_W-1:0]            net_rx_data_i,
  input  logic                         net_rx_enable_i,
  output logic                         net_rx_credit_o,
  output logic [FLIT_W-1:0]            core_rx_data_o,
  output logic                         core_rx_valid_o,
  input  logic                         core_rx_ready_i,
  output logic [$clog2(CREDITS+1)-1:0] credit_cnt_o,
  output logic [ERR_W-1:0]             err_o
);

  localparam int CW = $clog2(CREDITS + 1);

  flit_t            tx_head_s;
  logic             tx_full_s;
  logic             tx_empty_s;
  logic             tx_accept_s;
  logic             send_s;
  flit_t            rx_head_s;
  logic             rx_full_s;
  logic             rx_empty_s;
  logic             rx_pop_s;
  logic             rx_accept_s;
  logic             rx_overflow_s;
  logic             rx_misroute_s;
  logic [CW-1:0]    credit_cnt_r;
  flit_t            net_tx_data_r;
  logic             net_tx_enable_r;
  logic             net_rx_credit_r;
  logic [ERR_W-1:0] err_r;

  // Handshake qualification for both paths.
  always_comb begin
    tx_accept_s   = core_tx_valid_i && !tx_full_s;
    send_s        = !tx_empty_s && (credit_cnt_r != {CW{1'b0}});
    rx_pop_s      = !rx_empty_s && core_rx_ready_i;
    rx_accept_s   = net_rx_enable_i && (!rx_full_s || rx_pop_s);
    rx_overflow_s = net_rx_enable_i && rx_full_s && !rx_pop_s;
    rx_misroute_s = rx_accept_s &&
                    !is_local(net_rx_data_i, 4'(XCOORD), 4'(YCOORD));
  end

  noc_sync_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_accept_s),
    .wr_data (core_tx_data_i),
    .rd_en   (send_s),
    .rd_data (tx_head_s),
    .full    (tx_full_s),
    .empty   (tx_empty_s)
  );

  noc_sync_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (net_rx_enable_i),
    .wr_data (net_rx_data_i),
    .rd_en   (rx_pop_s),
    .rd_data (rx_head_s),
    .full    (rx_full_s),
    .empty   (rx_empty_s)
  );

  // Registered injection strobe; data holds its last value between sends.
  always_ff @(posedge clk) begin
    if (rst) begin
      net_tx_enable_r <= 1'b0;
      net_tx_data_r   <= {FLIT_W{1'b0}};
    end else begin
      net_tx_enable_r <= send_s;
      if (send_s) begin
        net_tx_data_r <= tx_head_s;
      end
    end
  end

  // TX credit counter; a credit arriving with the counter full saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt_r <= CW'(CREDITS);
    end else begin
      case ({send_s, net_tx_credit_i})
        2'b10: credit_cnt_r <= credit_cnt_r - CW'(1);
        2'b01: begin
          if (credit_cnt_r != CW'(CREDITS)) begin
            credit_cnt_r <= credit_cnt_r + CW'(1);
          end
        end
        default: credit_cnt_r <= credit_cnt_r;
      endcase
    end
  end

  // One credit pulse back to the router for each flit the core pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      net_rx_credit_r <= 1'b0;
    end else begin
      net_rx_credit_r <= rx_pop_s;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= {ERR_W{1'b0}};
    end else begin
      if (net_tx_credit_i && !send_s && (credit_cnt_r == CW'(CREDITS))) begin
        err_r[ERR_CREDIT_OVF] <= 1'b1;
      end
      if (rx_overflow_s) begin
        err_r[ERR_RX_OVF] <= 1'b1;
      end
      if (rx_misroute_s) begin
        err_r[ERR_MISROUTE] <= 1'b1;
      end
    end
  end

  assign core_tx_ready_o = !tx_full_s;
  assign net_tx_data_o   = net_tx_data_r;
  assign net_tx_enable_o = net_tx_enable_r;
  assign net_rx_credit_o = net_rx_credit_r;
  assign core_rx_data_o  = rx_head_s;
  assign core_rx_valid_o = !rx_empty_s;
  assign credit_cnt_o    = credit_cnt_r;
  assign err_o           = err_r;

endmodule
